uart_flash_loader: RTL

- Successor to the single-mode COM-to-flash writer: a command-driven loader between the UART byte interface and the flash driver.
- Supports WRITE, READ (read-back to the PC) and ERASE commands.
- Flash address width, data word width, address byte count and checksum seed are all parametrised.
- A one-word holding buffer absorbs flash-busy stalls during writes. Protocol errors are reported with a NAK byte instead of a dead-end state.

---
 rtl/uart_flash_loader.sv | 367 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_flash_loader.sv
// uart_flash_loader
//   Command-driven loader sitting between a UART byte interface and a flash
//   driver. It accepts WRITE, READ (read-back to the host) and ERASE commands.
//   Each command carries an address field. The loader answers with a checksum
//   of that field, then with a checksum of the data phase, or with a NAK byte
//   on a protocol error.
//
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     rx_data / rx_valid            received UART byte and its one-cycle strobe
//     tx_data / tx_start / tx_busy  byte to send, its start strobe, and the
//                                   transmitter busy flag
//     flash_addr / flash_wdata      word address and write data for the driver
//     flash_rdata                   read data, valid once busy falls after a read
//     flash_read/write/erase        one-cycle requests to the flash driver
//     flash_busy                    flash driver busy
//     state_dbg                     current FSM state encoding
//     word_cnt                      words written or read since the last command
//     err_overrun, err_cmd          sticky error flags
module uart_flash_loader #(
  parameter int unsigned FLASH_ADDR_SIZE = 22,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ADDR_BYTES      = 3,
  parameter logic [7:0]  CHECKSUM_INIT   = 8'h23,
  parameter logic [7:0]  CMD_WRITE       = 8'hf3,
  parameter logic [7:0]  CMD_READ        = 8'hf4,
  parameter logic [7:0]  CMD_ERASE       = 8'hf5,
  parameter logic [7:0]  NAK             = 8'hee
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [FLASH_ADDR_SIZE-1:0] flash_addr,
  output logic [DATA_WIDTH-1:0]      flash_wdata,
  input  logic [DATA_WIDTH-1:0]      flash_rdata,
  output logic                       flash_read,
  output logic                       flash_write,
  output logic                       flash_erase,
  input  logic                       flash_busy,
  output logic [3:0]                 state_dbg,
  output logic [FLASH_ADDR_SIZE-1:0] word_cnt,
  output logic                       err_overrun,
  output logic                       err_cmd
);

  localparam int unsigned WB  = DATA_WIDTH / 8;
  localparam int unsigned BCW = (WB > 1) ? $clog2(WB) : 1;
  localparam int unsigned MCW = $clog2(2 * ADDR_BYTES + 1);
  localparam int unsigned FAS = FLASH_ADDR_SIZE;

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_RECV_META     = 4'd1,
    S_SEND_META_ACK = 4'd2,
    S_WR_DATA       = 4'd3,
    S_RD_ISSUE      = 4'd4,
    S_RD_WAIT       = 4'd5,
    S_RD_SEND       = 4'd6,
    S_ER_ISSUE      = 4'd7,
    S_ER_WAIT       = 4'd8,
    S_SEND_DATA_ACK = 4'd9,
    S_SEND_NAK      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_ERASE = 2'd2
  } op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  // hi holds the start field of a two-field command; lo holds the end field,
  // or the only field of an erase. Bytes shift in from the bottom, so wire
  // bits above FAS fall off the top naturally.
  logic [FAS-1:0]        hi_q, hi_d;
  logic [FAS-1:0]        lo_q, lo_d;
  logic [MCW-1:0]        meta_left_q, meta_left_d;
  logic [7:0]            csum_q, csum_d;
  logic [FAS-1:0]        addr_q, addr_d;
  logic [FAS-1:0]        end_q, end_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [FAS-1:0]        buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [FAS-1:0]        word_cnt_q, word_cnt_d;
  logic                  err_overrun_q, err_overrun_d;
  logic                  err_cmd_q, err_cmd_d;
  // Last byte / address presented, so the outputs hold steady between strobes.
  logic [7:0]            tx_last_q;
  logic [FAS-1:0]        flash_addr_q;
  // One-cycle hold-offs after a strobe: the busy flags of the transmitter and
  // the flash driver are only trusted again one cycle after a request.
  logic                  tx_gap_q;
  logic                  fl_gap_q;

  logic                  tx_start_c, rd_c, wr_c, er_c;
  logic [7:0]            tx_byte_c;
  logic [FAS-1:0]        fa_c;
  logic                  tx_ok, fl_ok, drain;
  logic [FAS-1:0]        start_sel, end_sel, addr_inc;
  logic [DATA_WIDTH-1:0] word_next;

  assign tx_ok     = !tx_busy && !tx_gap_q;
  assign fl_ok     = !flash_busy && !fl_gap_q;
  assign start_sel = (op_q == OP_ERASE) ? lo_q : hi_q;
  assign end_sel   = lo_q;
  assign addr_inc  = addr_q + FAS'(1);
  assign word_next = (asm_q << 8) | DATA_WIDTH'(rx_data);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    meta_left_d   = meta_left_q;
    csum_d        = csum_q;
    addr_d        = addr_q;
    end_d         = end_q;
    asm_d         = asm_q;
    byte_cnt_d    = byte_cnt_q;
    buf_full_d    = buf_full_q;
    buf_data_d    = buf_data_q;
    buf_addr_d    = buf_addr_q;
    rd_data_d     = rd_data_q;
    word_cnt_d    = word_cnt_q;
    err_overrun_d = err_overrun_q;
    err_cmd_d     = err_cmd_q;
    tx_start_c    = 1'b0;
    tx_byte_c     = csum_q;
    rd_c          = 1'b0;
    wr_c          = 1'b0;
    er_c          = 1'b0;
    fa_c          = addr_q;
    drain         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ || rx_data == CMD_ERASE) begin
            state_d    = S_RECV_META;
            word_cnt_d = '0;
            csum_d     = CHECKSUM_INIT;
            buf_full_d = 1'b0;
            byte_cnt_d = '0;
            if (rx_data == CMD_ERASE) begin
              op_d        = OP_ERASE;
              meta_left_d = MCW'(ADDR_BYTES);
            end else begin
              op_d        = (rx_data == CMD_WRITE) ? OP_WRITE : OP_READ;
              meta_left_d = MCW'(2 * ADDR_BYTES);
            end
          end else begin
            err_cmd_d = 1'b1;
          end
        end
      end

      S_RECV_META: begin
        if (rx_valid) begin
          csum_d      = csum_q ^ rx_data;
          meta_left_d = meta_left_q - MCW'(1);
          // While more than one field's worth of bytes remain, the byte
          // belongs to the start field.
          if (op_q != OP_ERASE && meta_left_q > MCW'(ADDR_BYTES)) begin
            hi_d = (hi_q << 8) | FAS'(rx_data);
          end else begin
            lo_d = (lo_q << 8) | FAS'(rx_data);
          end
          if (meta_left_q == MCW'(1)) begin
            state_d = S_SEND_META_ACK;
          end
        end
      end

      S_SEND_META_ACK: begin
        if (tx_ok) begin
          tx_start_c = 1'b1;
          tx_byte_c  = csum_q;
          csum_d     = CHECKSUM_INIT;
          addr_d     = start_sel;
          end_d      = end_sel;
          byte_cnt_d = '0;
          if (op_q == OP_ERASE) begin
            state_d = S_ER_ISSUE;
          end else if (end_sel <= start_sel) begin
            // Empty or reversed range: no data phase at all.
            state_d = S_SEND_DATA_ACK;
          end else begin
            state_d = (op_q == OP_WRITE) ? S_WR_DATA : S_RD_ISSUE;
          end
        end
      end

      S_WR_DATA: begin
        if (buf_full_q && fl_ok) begin
          drain      = 1'b1;
          wr_c       = 1'b1;
          fa_c       = buf_addr_q;
          buf_full_d = 1'b0;
          word_cnt_d = word_cnt_q + FAS'(1);
        end
        // Bytes past the end of the range are ignored.
        if (rx_valid && addr_q != end_q) begin
          csum_d = csum_q ^ rx_data;
          asm_d  = word_next;
          if (byte_cnt_q == BCW'(WB - 1)) begin
            byte_cnt_d = '0;
            if (buf_full_q && !drain) begin
              // Second word finished while the first is still stuck.
              err_overrun_d = 1'b1;
              buf_full_d    = 1'b0;
              state_d       = S_SEND_NAK;
            end else begin
              buf_data_d = word_next;
              buf_addr_d = addr_q;
              buf_full_d = 1'b1;
              addr_d     = addr_inc;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
        if (addr_q == end_q && !buf_full_q && fl_ok) begin
          state_d = S_SEND_DATA_ACK;
        end
      end

      S_RD_ISSUE: begin
        if (addr_q == end_q) begin
          state_d = S_SEND_DATA_ACK;
        end else if (fl_ok) begin
          rd_c    = 1'b1;
          fa_c    = addr_q;
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (fl_ok) begin
          rd_data_d  = flash_rdata;
          byte_cnt_d = '0;
          state_d    = S_RD_SEND;
        end
      end

      S_RD_SEND: begin
        if (tx_ok) begin
          tx_start_c = 1'b1;
          tx_byte_c  = rd_data_q[DATA_WIDTH-1 -: 8];
          rd_data_d  = rd_data_q << 8;
          csum_d     = csum_q ^ rd_data_q[DATA_WIDTH-1 -: 8];
          if (byte_cnt_q == BCW'(WB - 1)) begin
            byte_cnt_d = '0;
            addr_d     = addr_inc;
            word_cnt_d = word_cnt_q + FAS'(1);
            state_d    = (addr_inc == end_q) ? S_SEND_DATA_ACK : S_RD_ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end

      S_ER_ISSUE: begin
        if (fl_ok) begin
          er_c    = 1'b1;
          fa_c    = addr_q;
          state_d = S_ER_WAIT;
        end
      end

      S_ER_WAIT: begin
        if (fl_ok) begin
          state_d = S_SEND_DATA_ACK;
        end
      end

      S_SEND_DATA_ACK: begin
        if (tx_ok) begin
          tx_start_c = 1'b1;
          tx_byte_c  = csum_q;
          state_d    = S_IDLE;
        end
      end

      S_SEND_NAK: begin
        if (tx_ok) begin
          tx_start_c = 1'b1;
          tx_byte_c  = NAK;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are masked while reset is asserted so an abort issues nothing.
  assign tx_start    = tx_start_c & ~rst;
  assign flash_read  = rd_c & ~rst;
  assign flash_write = wr_c & ~rst;
  assign flash_erase = er_c & ~rst;
  assign tx_data     = tx_start ? tx_byte_c : tx_last_q;
  assign flash_addr  = (flash_read || flash_write || flash_erase) ? fa_c : flash_addr_q;
  assign flash_wdata = buf_data_q;
  assign state_dbg   = state_q;
  assign word_cnt    = word_cnt_q;
  assign err_overrun = err_overrun_q;
  assign err_cmd     = err_cmd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_WRITE;
      hi_q          <= '0;
      lo_q          <= '0;
      meta_left_q   <= '0;
      csum_q        <= CHECKSUM_INIT;
      addr_q        <= '0;
      end_q         <= '0;
      asm_q         <= '0;
      byte_cnt_q    <= '0;
      buf_full_q    <= 1'b0;
      buf_data_q    <= '0;
      buf_addr_q    <= '0;
      rd_data_q     <= '0;
      word_cnt_q    <= '0;
      err_overrun_q <= 1'b0;
      err_cmd_q     <= 1'b0;
      tx_last_q     <= '0;
      flash_addr_q  <= '0;
      tx_gap_q      <= 1'b0;
      fl_gap_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      meta_left_q   <= meta_left_d;
      csum_q        <= csum_d;
      addr_q        <= addr_d;
      end_q         <= end_d;
      asm_q         <= asm_d;
      byte_cnt_q    <= byte_cnt_d;
      buf_full_q    <= buf_full_d;
      buf_data_q    <= buf_data_d;
      buf_addr_q    <= buf_addr_d;
      rd_data_q     <= rd_data_d;
      word_cnt_q    <= word_cnt_d;
      err_overrun_q <= err_overrun_d;
      err_cmd_q     <= err_cmd_d;
      tx_last_q     <= tx_data;
      flash_addr_q  <= flash_addr;
      tx_gap_q      <= tx_start;
      fl_gap_q      <= flash_read | flash_write | flash_erase;
    end
  end

endmodule
